// File: rtl/assoc_cache_pkg.sv
// Shared widths, request encoding and sizing helpers for the fully associative cache.
package cache_pkg;

    localparam int unsigned ADDR_W_DEF  = 8;
    localparam int unsigned DATA_W_DEF  = 32;
    localparam int unsigned ENTRIES_DEF = 4;

    typedef enum logic [1:0] {
        REQ_IDLE  = 2'd0,
        REQ_READ  = 2'd1,
        REQ_WRITE = 2'd2,
        REQ_FLUSH = 2'd3
    } req_kind_e;

    function automatic bit entries_ok(input int unsigned n);
        return (n >= 2) && ((n & (n - 1)) == 0);
    endfunction

    function automatic int unsigned ptr_w(input int unsigned n);
        return $clog2(n);
    endfunction

    // Flush outranks write, write outranks read.
    function automatic req_kind_e decode_req(input logic rd, input logic wr, input logic fl);
        if (fl)      return REQ_FLUSH;
        else if (wr) return REQ_WRITE;
        else if (rd) return REQ_READ;
        else         return REQ_IDLE;
    endfunction

endpackage

// File: rtl/assoc_cache_if.sv
// Requester-side bus of the associative cache: request inputs and registered results.
interface assoc_cache_if
    import cache_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
);
    logic [ADDR_W-1:0] in_addr;
    logic [DATA_W-1:0] in_val;
    logic              read;
    logic              write;
    logic              flush;
    logic              hit;
    logic [DATA_W-1:0] out_val;
    logic              full;

    modport master (
        output in_addr, in_val, read, write, flush,
        input  hit, out_val, full
    );

    modport slave (
        input  in_addr, in_val, read, write, flush,
        output hit, out_val, full
    );
endinterface

// File: rtl/assoc_cache_entry.sv
// One cache entry: valid bit, tag and data word with a combinational tag match.
module cache_entry #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              we_i,
    input  logic              clr_i,
    input  logic [ADDR_W-1:0] tag_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic              match_c_o
);
    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] tag_q;
    logic [DATA_W-1:0] data_q;

    // Clear wins over write so a flush can never leave a freshly filled entry.
    always_comb begin
        valid_d = valid_q;
        if (clr_i)     valid_d = 1'b0;
        else if (we_i) valid_d = 1'b1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) valid_q <= 1'b0;
        else          valid_q <= valid_d;
    end

    // Tag and data are qualified by valid, so they need no reset.
    always_ff @(posedge clock) begin
        if (we_i && !clr_i) begin
            tag_q  <= tag_i;
            data_q <= data_i;
        end
    end

    assign valid_o   = valid_q;
    assign data_o    = data_q;
    assign match_c_o = valid_q && (tag_q == tag_i);
endmodule

// File: rtl/assoc_cache.sv
// Fully associative cache with round-robin replacement and single-cycle flush.
module assoc_cache
    import cache_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned ENTRIES = ENTRIES_DEF
) (
    input  logic         clock,
    input  logic         reset_n,
    assoc_cache_if.slave bus
);
    localparam int unsigned PTR_W = ptr_w(ENTRIES);

    if (!entries_ok(ENTRIES)) begin : g_bad_entries
        $error("assoc_cache: ENTRIES must be a power of two and at least 2");
    end

    req_kind_e         req;
    logic [ENTRIES-1:0] match, valid, we, valid_d;
    logic [DATA_W-1:0]  ent_data [ENTRIES];
    logic [PTR_W-1:0]   hit_idx, fill_idx;
    logic               hit_any, all_valid;

    logic [PTR_W-1:0]  victim_q, victim_d;
    logic              hit_q, hit_d;
    logic [DATA_W-1:0] out_val_q, out_val_d;
    logic              full_q, full_d;

    for (genvar g = 0; g < ENTRIES; g++) begin : g_entry
        cache_entry #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_entry (
            .clock     (clock),
            .reset_n   (reset_n),
            .we_i      (we[g]),
            .clr_i     (req == REQ_FLUSH),
            .tag_i     (bus.in_addr),
            .data_i    (bus.in_val),
            .valid_o   (valid[g]),
            .data_o    (ent_data[g]),
            .match_c_o (match[g])
        );
    end

    assign req       = decode_req(bus.read, bus.write, bus.flush);
    assign hit_any   = |match;
    assign all_valid = &valid;

    // Match is at most one-hot, so OR-ing indices yields the matching entry.
    always_comb begin
        hit_idx = '0;
        for (int unsigned i = 0; i < ENTRIES; i++)
            if (match[i]) hit_idx = hit_idx | PTR_W'(i);
    end

    always_comb begin
        fill_idx = '0;
        for (int i = int'(ENTRIES) - 1; i >= 0; i--)
            if (!valid[i]) fill_idx = PTR_W'(i);
    end

    // Write target: update on hit, else lowest free slot, else the victim.
    always_comb begin
        we = '0;
        if (req == REQ_WRITE) begin
            if (hit_any)         we = match;
            else if (!all_valid) we[fill_idx] = 1'b1;
            else                 we[victim_q] = 1'b1;
        end
    end

    always_comb begin
        valid_d   = (req == REQ_FLUSH) ? '0 : (valid | we);
        full_d    = &valid_d;
        victim_d  = victim_q;
        hit_d     = 1'b0;
        out_val_d = out_val_q;
        case (req)
            REQ_FLUSH: victim_d = '0;
            REQ_WRITE: begin
                hit_d = hit_any;
                if (!hit_any && all_valid) victim_d = victim_q + PTR_W'(1);
            end
            REQ_READ: begin
                hit_d     = hit_any;
                out_val_d = hit_any ? ent_data[hit_idx] : '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            victim_q  <= '0;
            hit_q     <= 1'b0;
            out_val_q <= '0;
            full_q    <= 1'b0;
        end else begin
            victim_q  <= victim_d;
            hit_q     <= hit_d;
            out_val_q <= out_val_d;
            full_q    <= full_d;
        end
    end

    assign bus.hit     = hit_q;
    assign bus.out_val = out_val_q;
    assign bus.full    = full_q;
endmodule

// File: tb/tb_assoc_cache.sv
// Scoreboard bench for assoc_cache: a behavioural cache model predicts every result.
module tb_assoc_cache;
    import cache_pkg::*;

    typedef struct {
        logic        hit;
        logic [31:0] val;
        logic        full;
    } exp_t;

    typedef struct {
        bit          rd;
        bit          wr;
        bit          fl;
        logic [7:0]  a;
        logic [31:0] d;
    } op_t;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    assoc_cache_if #(.ADDR_W(8), .DATA_W(32)) bus ();

    assoc_cache #(.ADDR_W(8), .DATA_W(32), .ENTRIES(4)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int vectors = 0;
    int miscompares = 0;
    exp_t sb[$];

    bit          m_valid [4];
    logic [7:0]  m_tag   [4];
    logic [31:0] m_data  [4];
    int          m_ptr;
    logic        m_hit;
    logic [31:0] m_out;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_valid[i] = 0;
        m_ptr = 0; m_hit = 0; m_out = '0;
    endtask

    task automatic model_step(input op_t o);
        int   mi, fi, t;
        exp_t e;
        mi = -1; fi = -1;
        for (int i = 0; i < 4; i++) if (m_valid[i] && m_tag[i] == o.a) mi = i;
        for (int i = 3; i >= 0; i--) if (!m_valid[i]) fi = i;
        if (o.fl) begin
            for (int i = 0; i < 4; i++) m_valid[i] = 0;
            m_ptr = 0; m_hit = 0;
        end else if (o.wr) begin
            if (mi >= 0) begin
                m_data[mi] = o.d; m_hit = 1;
            end else begin
                if (fi >= 0) t = fi;
                else begin t = m_ptr; m_ptr = (m_ptr + 1) % 4; end
                m_tag[t] = o.a; m_data[t] = o.d; m_valid[t] = 1; m_hit = 0;
            end
        end else if (o.rd) begin
            m_hit = (mi >= 0);
            m_out = (mi >= 0) ? m_data[mi] : 32'h0;
        end else begin
            m_hit = 0;
        end
        e.hit  = m_hit;
        e.val  = m_out;
        e.full = m_valid[0] && m_valid[1] && m_valid[2] && m_valid[3];
        sb.push_back(e);
    endtask

    // Drive one request on the falling edge, predict it, then sample just after the rising edge.
    task automatic apply(input op_t o);
        @(negedge clock);
        bus.read = o.rd; bus.write = o.wr; bus.flush = o.fl;
        bus.in_addr = o.a; bus.in_val = o.d;
        model_step(o);
        @(posedge clock);
        #1;
        bus.read = 0; bus.write = 0; bus.flush = 0;
    endtask

    function automatic op_t rd_op(input logic [7:0] a);
        op_t o; o.rd = 1; o.wr = 0; o.fl = 0; o.a = a; o.d = '0; return o;
    endfunction
    function automatic op_t wr_op(input logic [7:0] a, input logic [31:0] d);
        op_t o; o.rd = 0; o.wr = 1; o.fl = 0; o.a = a; o.d = d; return o;
    endfunction
    function automatic op_t idle_op();
        op_t o; o.rd = 0; o.wr = 0; o.fl = 0; o.a = '0; o.d = '0; return o;
    endfunction

    task automatic test_reset();
        op_t  q[$];
        exp_t e;
        reset_n = 0;
        bus.read = 0; bus.write = 0; bus.flush = 0; bus.in_addr = '0; bus.in_val = '0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        vectors++;
        if ({bus.hit, bus.out_val, bus.full} !== 34'h0) begin
            miscompares++;
            $display("FAIL reset_state: got hit=%b out_val=%h full=%b want all zero", bus.hit, bus.out_val, bus.full);
        end
        @(negedge clock);
        reset_n = 1;
        q = '{idle_op(), idle_op(), idle_op(), rd_op(8'h10)};
        foreach (q[k]) begin
            apply(q[k]);
            e = sb.pop_front();
            vectors++;
            if (bus.hit !== e.hit || bus.out_val !== e.val || bus.full !== e.full) begin
                miscompares++;
                $display("FAIL reset_idle[%0d]: got hit=%b val=%h full=%b want hit=%b val=%h full=%b",
                         k, bus.hit, bus.out_val, bus.full, e.hit, e.val, e.full);
            end
        end
    endtask

    task automatic test_write_hit();
        op_t  q[$];
        exp_t e;
        q = '{wr_op(8'h10, 32'hAAAA0001), rd_op(8'h10), wr_op(8'h10, 32'hBBBB0002), rd_op(8'h10)};
        foreach (q[k]) begin
            apply(q[k]);
            e = sb.pop_front();
            vectors++;
            if (bus.hit !== e.hit || bus.out_val !== e.val || bus.full !== e.full) begin
                miscompares++;
                $display("FAIL write_hit[%0d]: got hit=%b val=%h full=%b want hit=%b val=%h full=%b",
                         k, bus.hit, bus.out_val, bus.full, e.hit, e.val, e.full);
            end
        end
        vectors++;
        if (bus.hit !== 1'b1 || bus.out_val !== 32'hBBBB0002) begin
            miscompares++;
            $display("FAIL write_hit_final: got hit=%b val=%h want hit=1 val=bbbb0002", bus.hit, bus.out_val);
        end
    endtask

    task automatic test_eviction();
        op_t  q[$];
        exp_t e;
        apply('{rd: 0, wr: 0, fl: 1, a: 8'h0, d: 32'h0});
        void'(sb.pop_front());
        for (int i = 1; i <= 4; i++) q.push_back(wr_op(8'(i), 32'hC000_0000 | 32'(i)));
        q.push_back(wr_op(8'h05, 32'hC000_0005));
        q.push_back(rd_op(8'h01));
        q.push_back(rd_op(8'h05));
        for (int i = 6; i <= 8; i++) q.push_back(wr_op(8'(i), 32'hC000_0000 | 32'(i)));
        q.push_back(rd_op(8'h02));
        q.push_back(wr_op(8'h09, 32'hC000_0009));
        q.push_back(rd_op(8'h05));
        q.push_back(rd_op(8'h08));
        foreach (q[k]) begin
            apply(q[k]);
            e = sb.pop_front();
            vectors++;
            if (bus.hit !== e.hit || bus.out_val !== e.val || bus.full !== e.full) begin
                miscompares++;
                $display("FAIL eviction[%0d]: got hit=%b val=%h full=%b want hit=%b val=%h full=%b",
                         k, bus.hit, bus.out_val, bus.full, e.hit, e.val, e.full);
            end
        end
        vectors++;
        if (bus.hit !== 1'b1 || bus.out_val !== 32'hC000_0008 || bus.full !== 1'b1) begin
            miscompares++;
            $display("FAIL eviction_final: got hit=%b val=%h full=%b want 1 c0000008 1", bus.hit, bus.out_val, bus.full);
        end
    endtask

    task automatic test_flush();
        op_t  q[$];
        exp_t e;
        for (int i = 1; i <= 4; i++) q.push_back(wr_op(8'(i), 32'hD000_0000 | 32'(i)));
        q.push_back('{rd: 0, wr: 1, fl: 1, a: 8'h09, d: 32'hDEAD_0009});
        q.push_back(rd_op(8'h09));
        q.push_back(rd_op(8'h01));
        q.push_back(wr_op(8'h0A, 32'hD000_000A));
        q.push_back(rd_op(8'h0A));
        foreach (q[k]) begin
            apply(q[k]);
            e = sb.pop_front();
            vectors++;
            if (bus.hit !== e.hit || bus.out_val !== e.val || bus.full !== e.full) begin
                miscompares++;
                $display("FAIL flush[%0d]: got hit=%b val=%h full=%b want hit=%b val=%h full=%b",
                         k, bus.hit, bus.out_val, bus.full, e.hit, e.val, e.full);
            end
        end
        vectors++;
        if (bus.full !== 1'b0 || bus.out_val !== 32'hD000_000A) begin
            miscompares++;
            $display("FAIL flush_final: got full=%b val=%h want full=0 val=d000000a", bus.full, bus.out_val);
        end
    endtask

    task automatic test_rw_priority();
        op_t  q[$];
        exp_t e;
        q = '{'{rd: 1, wr: 1, fl: 0, a: 8'h20, d: 32'h12345678}, rd_op(8'h20),
              idle_op(), '{rd: 1, wr: 1, fl: 0, a: 8'h20, d: 32'h0BAD_F00D}, rd_op(8'h20)};
        foreach (q[k]) begin
            apply(q[k]);
            e = sb.pop_front();
            vectors++;
            if (bus.hit !== e.hit || bus.out_val !== e.val || bus.full !== e.full) begin
                miscompares++;
                $display("FAIL rw_priority[%0d]: got hit=%b val=%h full=%b want hit=%b val=%h full=%b",
                         k, bus.hit, bus.out_val, bus.full, e.hit, e.val, e.full);
            end
        end
    endtask

    task automatic test_async_reset();
        op_t  q[$];
        exp_t e;
        apply('{rd: 0, wr: 0, fl: 1, a: 8'h0, d: 32'h0});
        void'(sb.pop_front());
        q = '{wr_op(8'h30, 32'hE000_0030), wr_op(8'h31, 32'hE000_0031), rd_op(8'h30)};
        foreach (q[k]) begin
            apply(q[k]);
            e = sb.pop_front();
            vectors++;
            if (bus.hit !== e.hit || bus.out_val !== e.val || bus.full !== e.full) begin
                miscompares++;
                $display("FAIL async_pre[%0d]: got hit=%b val=%h full=%b want hit=%b val=%h full=%b",
                         k, bus.hit, bus.out_val, bus.full, e.hit, e.val, e.full);
            end
        end
        @(negedge clock);
        bus.write = 1; bus.in_addr = 8'h32; bus.in_val = 32'hE000_0032;
        #2 reset_n = 0;
        #1;
        vectors++;
        if ({bus.hit, bus.out_val, bus.full} !== 34'h0) begin
            miscompares++;
            $display("FAIL async_reset: got hit=%b out_val=%h full=%b want all zero", bus.hit, bus.out_val, bus.full);
        end
        bus.write = 0;
        model_reset();
        @(negedge clock);
        reset_n = 1;
        q = '{rd_op(8'h30), rd_op(8'h31), rd_op(8'h32)};
        foreach (q[k]) begin
            apply(q[k]);
            e = sb.pop_front();
            vectors++;
            if (bus.hit !== e.hit || bus.out_val !== e.val || bus.full !== e.full) begin
                miscompares++;
                $display("FAIL async_post[%0d]: got hit=%b val=%h full=%b want hit=%b val=%h full=%b",
                         k, bus.hit, bus.out_val, bus.full, e.hit, e.val, e.full);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_hit();
        test_eviction();
        test_flush();
        test_rw_priority();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/assoc_cache.md
# assoc_cache

Fully associative cache with parameterised address width, data width and entry count. It generalises the single-entry cache line to ENTRIES tagged entries, each with its own valid bit. Replacement is round-robin, and a flush clears every entry in one cycle. It sits between a requester issuing single-cycle read/write requests and backing storage that handles misses; the block itself never talks to backing storage.

## Interface
Parameters:
- ADDR_W, default 8: address/tag width in bits.
- DATA_W, default 32: data width in bits.
- ENTRIES, default 4: number of entries; must be a power of two and at least 2.

Ports:
- clock  input  1  single clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_addr  input  ADDR_W  request address, used as the full tag.
- in_val  input  DATA_W  write data.
- read  input  1  read request this cycle.
- write  input  1  write request this cycle.
- flush  input  1  invalidate all entries.
- hit  output  1  registered; 1 when the request sampled at the last edge matched a valid entry.
- out_val  output  DATA_W  registered read data.
- full  output  1  registered; 1 when every entry is valid.

## Operation
- Per entry, the block holds a valid bit, an ADDR_W tag and a DATA_W data word. There is also a victim pointer of log2(ENTRIES) bits.
- Lookup: compare in_addr against every valid tag in parallel. At most one entry can match; the block guarantees this by construction.
- Priority at each edge is flush > write > read. Lower-priority requests in the same cycle are dropped, with no side effects.
- Flush:
  - all valid bits go to 0 and the victim pointer goes to 0;
  - hit goes to 0; out_val holds its value.
- Write hit: the matching entry's data becomes in_val; hit goes to 1; the victim pointer is unchanged.
- Write miss, some entry invalid: fill the lowest-index invalid entry (tag, data, valid=1). hit goes to 0 and the victim pointer is unchanged.
- Write miss, all entries valid: overwrite the entry at the victim pointer. hit goes to 0 and the victim pointer increments modulo ENTRIES, wrapping from ENTRIES-1 to 0.
- Read hit: out_val takes the matching entry's data and hit goes to 1.
- Read miss: out_val goes to 0 and hit goes to 0.
- Idle (no read, write or flush): hit goes to 0; out_val and all other state hold.
- A write never changes out_val.
- full is recomputed every edge from the next-state valid bits.

## Timing
- Reset values: hit=0, out_val=0, full=0, all valid=0, victim pointer=0. Tag and data contents are don't-care.
- Asserting reset_n low mid-request aborts that request; no entry update survives.
- Latency is one cycle. A request sampled at edge N produces hit/out_val/full valid after edge N, and they hold until edge N+1.
- A read at edge N+1 of an address written at edge N hits and returns the new data.
- Requests are accepted every cycle. There is no backpressure and no stall.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Package cache_pkg holds:
  - the default widths;
  - the ENTRIES power-of-two check;
  - the log2(ENTRIES) pointer-width function/constant;
  - a request-kind encoding (IDLE, READ, WRITE, FLUSH) produced by the priority decode.
- Sub-module cache_entry holds one entry's valid bit, tag and data. It takes write-enable and clear-valid inputs and produces a combinational match output. assoc_cache instantiates ENTRIES copies and adds:
  - priority decode;
  - one-hot to index encoding;
  - first-invalid selection;
  - victim pointer;
  - output registers.

## Test plan
All scenarios use the defaults ADDR_W=8, DATA_W=32, ENTRIES=4.
1. Reset, then idle for 3 cycles -> hit=0, out_val=0, full=0. Read 0x10 -> hit=0, out_val=0.
2. Write 0x10/0xAAAA0001, then read 0x10 on the next cycle -> hit=1, out_val=0xAAAA0001. Write 0x10/0xBBBB0002 -> hit=1; a following read returns 0xBBBB0002.
3. Write 0x01..0x04 -> full=1 after the 4th write. Write 0x05 -> entry 0 is evicted and the pointer goes to 1. Read 0x01 -> hit=0; read 0x05 -> hit=1. Write 0x06..0x08 -> the pointer wraps to 0. Read 0x02 -> hit=0.
4. Fill all 4 entries, then assert flush together with write 0x09 -> hit=0, full=0, and the write is dropped. Read 0x09 and read 0x01 -> both hit=0.
5. Assert read and write to 0x20/0x12345678 in the same cycle -> the write is taken, hit=0, out_val unchanged. The next read of 0x20 -> hit=1, out_val=0x12345678.
6. With 2 entries valid, pull reset_n low asynchronously between edges -> outputs go to reset values immediately. After release, reads of both addresses -> hit=0.
